uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_core.sv | 154 +++++++++++++++
 tb/tb_uart_rx_core.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame parameters.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_rx_state_t;

   localparam int unsigned UART_CLKS_PER_BIT_DEF = 10;
   localparam int unsigned UART_DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value selectable
// so idle-high lines (RX, CTS) do not produce a spurious edge out of reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic sync1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RST_VAL;
         q     <= RST_VAL;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1-style UART receiver (LSB first, idle high) with mid-bit sampling and a
// single-entry valid/ready holding register; flags framing errors and overruns.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int unsigned DATA_BITS    = UART_DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   uart_rx_state_t       state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 stop_done;

   logic rx_s;
   logic rx_s_d;
   logic fall;

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_i),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s_d <= 1'b1;
      end else begin
         rx_s_d <= rx_s;
      end
   end

   assign fall = !rx_s && rx_s_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // START times only half a bit so every later terminal count lands mid-bit.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      stop_done   = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt     = '0;
               shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
               bit_idx_nxt = bit_idx + 1'b1;
               if (bit_idx == IDX_LAST) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               stop_done = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A load on the same edge as a transfer overrides the clear, keeping valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= (state_nxt != IDLE);
         if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
         if (stop_done) begin
            if (rx_s) begin
               if (!rx_valid_o || rx_ready_i) begin
                  rx_data_o  <= shreg;
                  rx_valid_o <= 1'b1;
               end else begin
                  overrun_o <= 1'b1;
               end
            end else begin
               frame_err_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: default instance plus a 16-clk/7-bit instance.
module tb_uart_rx_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       rx_a, rx_b;
   logic       ready_a, ready_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       valid_a, ferr_a, ovr_a, busy_a;
   logic       valid_b, ferr_b, ovr_b, busy_b;

   int unsigned cyc = 0;
   int unsigned ferr_cnt = 0;
   int unsigned ovr_cnt = 0;
   int tests = 0;
   int fails = 0;

   uart_rx_core dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (rx_a),
      .rx_data_o   (data_a),
      .rx_valid_o  (valid_a),
      .rx_ready_i  (ready_a),
      .frame_err_o (ferr_a),
      .overrun_o   (ovr_a),
      .busy_o      (busy_a)
   );

   uart_rx_core #(
      .CLKS_PER_BIT (16),
      .DATA_BITS    (7)
   ) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_i        (rx_b),
      .rx_data_o   (data_b),
      .rx_valid_o  (valid_b),
      .rx_ready_i  (ready_b),
      .frame_err_o (ferr_b),
      .overrun_o   (ovr_b),
      .busy_o      (busy_b)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ferr_a) ferr_cnt <= ferr_cnt + 1;
      if (ovr_a)  ovr_cnt  <= ovr_cnt + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic wait_edge(input int unsigned e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_line(input bit on_b, input logic v);
      if (on_b) rx_b = v;
      else      rx_a = v;
   endtask

   // Called at a negedge; the following posedge is E0 of the frame.
   task automatic send_frame(input logic [7:0] d, input int unsigned nbits,
                             input logic stop, input int unsigned cpb, input bit on_b);
      set_line(on_b, 1'b0);
      repeat (cpb) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         set_line(on_b, d[i]);
         repeat (cpb) @(negedge clk);
      end
      set_line(on_b, stop);
      repeat (cpb) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_a); end
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_a); end
      tests++; if (ferr_a !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", ferr_a); end
      tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", ovr_a); end
      tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_a); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single;
      int unsigned e0;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         send_frame(8'h55, 8, 1'b1, 10, 1'b0);
         begin
            wait_edge(e0 + 1);
            tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy_e1: got %b want 0", busy_a); end
            wait_edge(e0 + 2);
            tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL single_busy_e2: got %b want 1", busy_a); end
            wait_edge(e0 + 96);
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL single_valid_e96: got %b want 0", valid_a); end
            tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL single_busy_e96: got %b want 1", busy_a); end
            wait_edge(e0 + 97);
            tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL single_valid_e97: got %b want 1", valid_a); end
            tests++; if (data_a !== 8'h55) begin fails++; $display("FAIL single_data: got %h want 55", data_a); end
            tests++; if (ferr_a !== 1'b0 || ovr_a !== 1'b0) begin fails++; $display("FAIL single_flags: got ferr=%b ovr=%b want 0 0", ferr_a, ovr_a); end
            tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL single_busy_e97: got %b want 0", busy_a); end
            wait_edge(e0 + 98);
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL single_valid_e98: got %b want 0", valid_a); end
         end
      join
   endtask

   task automatic test_back_to_back;
      int unsigned e0;
      int unsigned ovr0;
      ovr0 = ovr_cnt;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         begin
            send_frame(8'hA3, 8, 1'b1, 10, 1'b0);
            send_frame(8'h0F, 8, 1'b1, 10, 1'b0);
         end
         begin
            wait_edge(e0 + 97);
            tests++; if (valid_a !== 1'b1 || data_a !== 8'hA3) begin fails++; $display("FAIL b2b_first: got valid=%b data=%h want 1 a3", valid_a, data_a); end
            wait_edge(e0 + 98);
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL b2b_gap: got %b want 0", valid_a); end
            wait_edge(e0 + 196);
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL b2b_e196: got %b want 0", valid_a); end
            wait_edge(e0 + 197);
            tests++; if (valid_a !== 1'b1 || data_a !== 8'h0F) begin fails++; $display("FAIL b2b_second: got valid=%b data=%h want 1 0f", valid_a, data_a); end
         end
      join
      tests++; if (ovr_cnt !== ovr0) begin fails++; $display("FAIL b2b_no_overrun: got %0d want %0d", ovr_cnt, ovr0); end
   endtask

   task automatic test_backpressure;
      int unsigned e0;
      int unsigned ovr0;
      ovr0 = ovr_cnt;
      @(negedge clk);
      ready_a = 1'b0;
      e0 = cyc + 1;
      fork
         begin
            send_frame(8'hA3, 8, 1'b1, 10, 1'b0);
            send_frame(8'h0F, 8, 1'b1, 10, 1'b0);
         end
         begin
            wait_edge(e0 + 97);
            tests++; if (valid_a !== 1'b1 || data_a !== 8'hA3) begin fails++; $display("FAIL bp_first: got valid=%b data=%h want 1 a3", valid_a, data_a); end
            wait_edge(e0 + 196);
            tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL bp_ovr_e196: got %b want 0", ovr_a); end
            wait_edge(e0 + 197);
            tests++; if (ovr_a !== 1'b1) begin fails++; $display("FAIL bp_ovr_pulse: got %b want 1", ovr_a); end
            tests++; if (valid_a !== 1'b1 || data_a !== 8'hA3) begin fails++; $display("FAIL bp_held: got valid=%b data=%h want 1 a3", valid_a, data_a); end
            wait_edge(e0 + 198);
            tests++; if (ovr_a !== 1'b0) begin fails++; $display("FAIL bp_ovr_e198: got %b want 0", ovr_a); end
         end
      join
      tests++; if (ovr_cnt - ovr0 !== 1) begin fails++; $display("FAIL bp_ovr_count: got %0d want 1", ovr_cnt - ovr0); end
      ready_a = 1'b1;
      @(posedge clk);
      #1;
      tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", valid_a); end
   endtask

   task automatic test_frame_error;
      int unsigned e0;
      int unsigned ferr0;
      ferr0 = ferr_cnt;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         send_frame(8'h3C, 8, 1'b0, 10, 1'b0);
         begin
            wait_edge(e0 + 96);
            tests++; if (ferr_a !== 1'b0) begin fails++; $display("FAIL ferr_e96: got %b want 0", ferr_a); end
            wait_edge(e0 + 97);
            tests++; if (ferr_a !== 1'b1) begin fails++; $display("FAIL ferr_pulse: got %b want 1", ferr_a); end
            tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL ferr_valid: got %b want 0", valid_a); end
            wait_edge(e0 + 98);
            tests++; if (ferr_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL ferr_e98: got ferr=%b busy=%b want 0 0", ferr_a, busy_a); end
         end
      join
      repeat (30) @(negedge clk);
      tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL ferr_stuck_low_busy: got %b want 0", busy_a); end
      rx_a = 1'b1;
      repeat (20) @(negedge clk);
      e0 = cyc + 1;
      fork
         send_frame(8'h81, 8, 1'b1, 10, 1'b0);
         begin
            wait_edge(e0 + 97);
            tests++; if (valid_a !== 1'b1 || data_a !== 8'h81) begin fails++; $display("FAIL ferr_recover: got valid=%b data=%h want 1 81", valid_a, data_a); end
         end
      join
      tests++; if (ferr_cnt - ferr0 !== 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - ferr0); end
   endtask

   task automatic test_glitch;
      int unsigned e0;
      int unsigned ferr0, ovr0;
      ferr0 = ferr_cnt;
      ovr0  = ovr_cnt;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         begin
            rx_a = 1'b0;
            repeat (3) @(negedge clk);
            rx_a = 1'b1;
         end
         begin
            wait_edge(e0 + 1);
            tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy_e1: got %b want 0", busy_a); end
            wait_edge(e0 + 2);
            tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL glitch_busy_e2: got %b want 1", busy_a); end
            wait_edge(e0 + 6);
            tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL glitch_busy_e6: got %b want 1", busy_a); end
            wait_edge(e0 + 7);
            tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy_e7: got %b want 0", busy_a); end
         end
      join
      wait_edge(e0 + 110);
      tests++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL glitch_quiet: got valid=%b busy=%b want 0 0", valid_a, busy_a); end
      tests++; if (ferr_cnt !== ferr0 || ovr_cnt !== ovr0) begin fails++; $display("FAIL glitch_flags: got ferr=%0d ovr=%0d want %0d %0d", ferr_cnt, ovr_cnt, ferr0, ovr0); end
   endtask

   task automatic test_reset_mid;
      int unsigned e0;
      int unsigned ferr0, ovr0;
      @(negedge clk);
      ready_a = 1'b0;
      send_frame(8'h5A, 8, 1'b1, 10, 1'b0);
      repeat (2) @(negedge clk);
      tests++; if (valid_a !== 1'b1 || data_a !== 8'h5A) begin fails++; $display("FAIL rmid_preload: got valid=%b data=%h want 1 5a", valid_a, data_a); end
      ferr0 = ferr_cnt;
      ovr0  = ovr_cnt;
      e0 = cyc + 1;
      fork
         send_frame(8'hFF, 8, 1'b1, 10, 1'b0);
         begin
            wait_edge(e0 + 52);
            @(negedge clk);
            tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rmid_busy_before: got %b want 1", busy_a); end
            rst_n = 1'b0;
            #1;
            tests++; if (valid_a !== 1'b0 || data_a !== 8'h00) begin fails++; $display("FAIL rmid_async_clear: got valid=%b data=%h want 0 00", valid_a, data_a); end
            tests++; if (busy_a !== 1'b0 || ferr_a !== 1'b0 || ovr_a !== 1'b0) begin fails++; $display("FAIL rmid_async_flags: got busy=%b ferr=%b ovr=%b want 0 0 0", busy_a, ferr_a, ovr_a); end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      wait_edge(e0 + 130);
      tests++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL rmid_no_output: got valid=%b busy=%b want 0 0", valid_a, busy_a); end
      tests++; if (ferr_cnt !== ferr0 || ovr_cnt !== ovr0) begin fails++; $display("FAIL rmid_flags: got ferr=%0d ovr=%0d want %0d %0d", ferr_cnt, ovr_cnt, ferr0, ovr0); end
      @(negedge clk);
      ready_a = 1'b1;
      e0 = cyc + 1;
      fork
         send_frame(8'h12, 8, 1'b1, 10, 1'b0);
         begin
            wait_edge(e0 + 97);
            tests++; if (valid_a !== 1'b1 || data_a !== 8'h12) begin fails++; $display("FAIL rmid_next: got valid=%b data=%h want 1 12", valid_a, data_a); end
         end
      join
   endtask

   task automatic test_param_sweep;
      int unsigned e0;
      @(negedge clk);
      e0 = cyc + 1;
      fork
         send_frame(8'h6A, 7, 1'b1, 16, 1'b1);
         begin
            wait_edge(e0 + 137);
            tests++; if (valid_b !== 1'b0 || busy_b !== 1'b1) begin fails++; $display("FAIL sweep_e137: got valid=%b busy=%b want 0 1", valid_b, busy_b); end
            wait_edge(e0 + 138);
            tests++; if (valid_b !== 1'b1 || data_b !== 7'h6A) begin fails++; $display("FAIL sweep_e138: got valid=%b data=%h want 1 6a", valid_b, data_b); end
            tests++; if (ferr_b !== 1'b0 || ovr_b !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL sweep_flags: got ferr=%b ovr=%b busy=%b want 0 0 0", ferr_b, ovr_b, busy_b); end
            wait_edge(e0 + 139);
            tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL sweep_e139: got %b want 0", valid_b); end
         end
      join
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_frame_error();
      test_glitch();
      test_reset_mid();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
